// File: rtl/pit_multichannel_if.sv
// Bus interface of pit_multichannel: IPIF-style user bus, grouped for module ports.
//   master : drives Bus2IP_Data/BE/RdCE/WrCE, receives IP2Bus_Data/RdAck/WrAck/Error
//   slave  : the timer side of the same bundle
interface pit_multichannel_if #(
  parameter int unsigned C_SLV_DWIDTH = 32,
  parameter int unsigned C_NUM_REG    = 7
);
  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data;
  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE;
  logic [C_NUM_REG-1:0]      Bus2IP_RdCE;
  logic [C_NUM_REG-1:0]      Bus2IP_WrCE;
  logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data;
  logic                      IP2Bus_RdAck;
  logic                      IP2Bus_WrAck;
  logic                      IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/pit_multichannel.sv
// Multi-channel programmable interval timer on the IPIF-style user bus.
// NUM_CH independent down-counters, each with an 8-bit prescaler, optional
// auto-reload and interrupt enable. Expiries latch into a shared W1C STATUS.
// Register map (register k selected by CE bit [C_NUM_REG-1-k]):
//   3c   CTRL   RW  bit0 EN, bit1 IE, bit2 RELOAD, bits[11:4] PRESC
//   3c+1 LOAD   RW  period value
//   3c+2 COUNT  RO  live counter (write -> Error, discarded)
//   3N   STATUS W1C bit c = channel c expired
// Ports:
//   Bus2IP_Clk    clock
//   Bus2IP_Resetn asynchronous active-low reset
//   bus           slave side of pit_multichannel_if (data, BE, CEs, acks, error)
//   IP_Interrupt  OR of Irq_Vec
//   Irq_Vec       registered STATUS & IE per channel
module pit_multichannel #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned C_SLV_DWIDTH = 32,
  parameter int unsigned C_NUM_REG    = 3*NUM_CH+1
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Resetn,
  pit_multichannel_if.slave   bus,
  output logic                IP_Interrupt,
  output logic [NUM_CH-1:0]   Irq_Vec
);

  localparam int unsigned DW     = C_SLV_DWIDTH;
  localparam int unsigned BW     = DW/8;
  localparam int unsigned ST_IDX = 3*NUM_CH;
  localparam int unsigned PSC_W  = 8;

  // Register state
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] ie_q, ie_d;
  logic [NUM_CH-1:0] rl_q, rl_d;
  logic [PSC_W-1:0]  presc_cfg_q [NUM_CH];
  logic [PSC_W-1:0]  presc_cfg_d [NUM_CH];
  logic [PSC_W-1:0]  psc_cnt_q   [NUM_CH];
  logic [PSC_W-1:0]  psc_cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  load_q      [NUM_CH];
  logic [CNT_W-1:0]  load_d      [NUM_CH];
  logic [CNT_W-1:0]  cnt_q       [NUM_CH];
  logic [CNT_W-1:0]  cnt_d       [NUM_CH];
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] irq_q, irq_d;

  // Decode
  logic [C_NUM_REG-1:0] rd_sel_c, wr_sel_c;
  logic                 rd_ok_c, wr_ok_c;
  logic [NUM_CH-1:0]    ctrl_wr_c, load_wr_c, cnt_wr_c, tick_c, expire_c;
  logic                 status_wr_c;
  logic [NUM_CH-1:0]    st_clr_c;
  logic [DW-1:0]        load_m_c [NUM_CH];
  logic [DW-1:0]        ctrl_word_c [NUM_CH];
  logic [DW-1:0]        rdata_c;
  logic                 err_c;

  function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int unsigned b = 0; b < BW; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic is_onehot(input logic [C_NUM_REG-1:0] v);
    return (v != '0) && ((v & (v - C_NUM_REG'(1))) == '0);
  endfunction

  // CE bit order is reversed: MSB selects register 0
  always_comb begin
    rd_sel_c = '0;
    wr_sel_c = '0;
    for (int unsigned k = 0; k < C_NUM_REG; k++) begin
      rd_sel_c[k] = bus.Bus2IP_RdCE[C_NUM_REG-1-k];
      wr_sel_c[k] = bus.Bus2IP_WrCE[C_NUM_REG-1-k];
    end
  end

  assign rd_ok_c = is_onehot(bus.Bus2IP_RdCE);
  assign wr_ok_c = is_onehot(bus.Bus2IP_WrCE);

  // Per-channel write strobes and prescaler ticks; a CTRL or LOAD write
  // restarts the prescaler and swallows a coincident tick
  always_comb begin
    ctrl_wr_c = '0;
    load_wr_c = '0;
    cnt_wr_c  = '0;
    tick_c    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ctrl_wr_c[c]   = wr_ok_c & wr_sel_c[3*c];
      load_wr_c[c]   = wr_ok_c & wr_sel_c[3*c+1];
      cnt_wr_c[c]    = wr_ok_c & wr_sel_c[3*c+2];
      tick_c[c]      = en_q[c] && (psc_cnt_q[c] == presc_cfg_q[c]) &&
                       !ctrl_wr_c[c] && !load_wr_c[c];
      load_m_c[c]    = be_merge(DW'(load_q[c]), bus.Bus2IP_Data, bus.Bus2IP_BE);
      ctrl_word_c[c] = DW'({presc_cfg_q[c], 1'b0, rl_q[c], ie_q[c], en_q[c]});
    end
  end

  assign status_wr_c = wr_ok_c & wr_sel_c[ST_IDX];
  assign st_clr_c    = (status_wr_c && bus.Bus2IP_BE[0]) ? bus.Bus2IP_Data[NUM_CH-1:0] : '0;

  // Next-state logic for configuration, prescalers, counters and status
  always_comb begin
    en_d        = en_q;
    ie_d        = ie_q;
    rl_d        = rl_q;
    presc_cfg_d = presc_cfg_q;
    psc_cnt_d   = psc_cnt_q;
    load_d      = load_q;
    cnt_d       = cnt_q;
    expire_c    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ctrl_wr_c[c]) begin
        if (bus.Bus2IP_BE[0]) begin
          en_d[c]             = bus.Bus2IP_Data[0];
          ie_d[c]             = bus.Bus2IP_Data[1];
          rl_d[c]             = bus.Bus2IP_Data[2];
          presc_cfg_d[c][3:0] = bus.Bus2IP_Data[7:4];
        end
        if (bus.Bus2IP_BE[1]) presc_cfg_d[c][7:4] = bus.Bus2IP_Data[11:8];
      end

      if (!en_q[c] || ctrl_wr_c[c] || load_wr_c[c] || tick_c[c]) begin
        psc_cnt_d[c] = '0;
      end else begin
        psc_cnt_d[c] = psc_cnt_q[c] + PSC_W'(1);
      end

      if (load_wr_c[c]) begin
        load_d[c] = CNT_W'(load_m_c[c]);
        cnt_d[c]  = CNT_W'(load_m_c[c]);
      end else if (tick_c[c]) begin
        if (cnt_q[c] > CNT_W'(1)) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end else if (cnt_q[c] == CNT_W'(1)) begin
          expire_c[c] = 1'b1;
          cnt_d[c]    = rl_q[c] ? load_q[c] : '0;
        end
      end
    end
    // Set beats clear on the same bit
    status_d = (status_q & ~st_clr_c) | expire_c;
    irq_d    = status_q & ie_q;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      en_q     <= '0;
      ie_q     <= '0;
      rl_q     <= '0;
      status_q <= '0;
      irq_q    <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        presc_cfg_q[c] <= '0;
        psc_cnt_q[c]   <= '0;
        load_q[c]      <= '0;
        cnt_q[c]       <= '0;
      end
    end else begin
      en_q        <= en_d;
      ie_q        <= ie_d;
      rl_q        <= rl_d;
      status_q    <= status_d;
      irq_q       <= irq_d;
      presc_cfg_q <= presc_cfg_d;
      psc_cnt_q   <= psc_cnt_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
    end
  end

  // Read mux; returns 0 unless exactly one RdCE is active
  always_comb begin
    rdata_c = '0;
    if (rd_ok_c) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (rd_sel_c[3*c])   rdata_c = ctrl_word_c[c];
        if (rd_sel_c[3*c+1]) rdata_c = DW'(load_q[c]);
        if (rd_sel_c[3*c+2]) rdata_c = DW'(cnt_q[c]);
      end
      if (rd_sel_c[ST_IDX]) rdata_c = DW'(status_q);
    end
  end

  assign err_c = ((|bus.Bus2IP_WrCE) && !wr_ok_c) ||
                 ((|bus.Bus2IP_RdCE) && !rd_ok_c) ||
                 (|cnt_wr_c);

  assign bus.IP2Bus_Data  = rdata_c;
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = err_c;

  assign Irq_Vec      = irq_q;
  assign IP_Interrupt = |irq_q;

endmodule

// File: tb/tb_pit_multichannel.sv
// Directed bench for pit_multichannel (NUM_CH=2, CNT_W=32).
module tb_pit_multichannel;

  localparam int unsigned NREG = 7;

  logic       clk;
  logic       rst_n;
  logic       IP_Interrupt;
  logic [1:0] Irq_Vec;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] rd_d;
  logic        rd_a, rd_e;
  logic        wa, we;

  pit_multichannel_if #(.C_SLV_DWIDTH(32), .C_NUM_REG(NREG)) bus_if ();

  pit_multichannel #(.NUM_CH(2), .CNT_W(32), .C_SLV_DWIDTH(32)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .bus           (bus_if),
    .IP_Interrupt  (IP_Interrupt),
    .Irq_Vec       (Irq_Vec)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int k, output logic [31:0] d, output logic a, output logic e);
    bus_if.Bus2IP_RdCE = NREG'(1) << (NREG-1-k);
    #1;
    d = bus_if.IP2Bus_Data;
    a = bus_if.IP2Bus_RdAck;
    e = bus_if.IP2Bus_Error;
    bus_if.Bus2IP_RdCE = '0;
    #1;
  endtask

  task automatic chk_rd(input string tag, input int k, input logic [31:0] exp);
    logic [31:0] d;
    logic a, e;
    rd(k, d, a, e);
    check(tag, d, exp);
  endtask

  // Write lands on the next rising edge
  task automatic wr(input int k, input logic [31:0] d, input logic [3:0] be);
    bus_if.Bus2IP_Data = d;
    bus_if.Bus2IP_BE   = be;
    bus_if.Bus2IP_WrCE = NREG'(1) << (NREG-1-k);
    #1;
    wa = bus_if.IP2Bus_WrAck;
    we = bus_if.IP2Bus_Error;
    @(posedge clk);
    #1;
    bus_if.Bus2IP_WrCE = '0;
    bus_if.Bus2IP_BE   = '0;
    bus_if.Bus2IP_Data = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.Bus2IP_Data = '0;
    bus_if.Bus2IP_BE   = '0;
    bus_if.Bus2IP_RdCE = '0;
    bus_if.Bus2IP_WrCE = '0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state and idle bus
    check("idle_data", bus_if.IP2Bus_Data, 32'h0);
    check("idle_rdack", 32'(bus_if.IP2Bus_RdAck), 32'h0);
    check("idle_wrack", 32'(bus_if.IP2Bus_WrAck), 32'h0);
    check("rst_irq", 32'(IP_Interrupt), 32'h0);
    check("rst_irqvec", 32'(Irq_Vec), 32'h0);
    for (int k = 0; k < 7; k++) begin
      rd(k, rd_d, rd_a, rd_e);
      check($sformatf("rst_reg%0d", k), rd_d, 32'h0);
      check($sformatf("rst_rdack%0d", k), 32'(rd_a), 32'h1);
      check($sformatf("rst_err%0d", k), 32'(rd_e), 32'h0);
    end

    // Ch0 one-shot, LOAD=30, PRESC=0
    wr(1, 32'd30, 4'hF);
    wr(0, 32'h1, 4'hF);
    step(29);
    chk_rd("os_cnt_29", 2, 32'd1);
    chk_rd("os_st_29", 6, 32'h0);
    step(1);
    chk_rd("os_cnt_30", 2, 32'd0);
    chk_rd("os_st_30", 6, 32'h1);
    step(5);
    chk_rd("os_hold", 2, 32'd0);
    check("os_noirq", 32'(IP_Interrupt), 32'h0);

    // Ch0 auto-reload with interrupt
    wr(6, 32'h1, 4'hF);
    chk_rd("st_clear", 6, 32'h0);
    wr(0, 32'h0, 4'hF);
    wr(1, 32'd30, 4'hF);
    wr(0, 32'h7, 4'hF);
    step(30);
    chk_rd("rl_st", 6, 32'h1);
    chk_rd("rl_cnt", 2, 32'd30);
    check("rl_irq_lat", 32'(Irq_Vec), 32'h0);
    step(1);
    check("rl_irqvec", 32'(Irq_Vec), 32'h1);
    check("rl_irq", 32'(IP_Interrupt), 32'h1);
    chk_rd("rl_cnt_31", 2, 32'd29);
    wr(6, 32'h1, 4'hF);
    check("w1c_wrack", 32'(wa), 32'h1);
    check("w1c_err", 32'(we), 32'h0);
    chk_rd("w1c_st", 6, 32'h0);
    check("w1c_irq_hold", 32'(IP_Interrupt), 32'h1);
    step(1);
    check("w1c_irq_drop", 32'(IP_Interrupt), 32'h0);
    step(26);
    chk_rd("rl2_cnt_59", 2, 32'd1);
    chk_rd("rl2_st_59", 6, 32'h0);
    step(1);
    chk_rd("rl2_st_60", 6, 32'h1);
    chk_rd("rl2_cnt_60", 2, 32'd30);

    // Ch1 LOAD=4, PRESC=3 alongside ch0
    wr(4, 32'd4, 4'hF);
    wr(3, 32'h37, 4'hF);
    step(15);
    chk_rd("c1_cnt_15", 5, 32'd1);
    chk_rd("c1_st_15", 6, 32'h1);
    step(1);
    chk_rd("c1_st_16", 6, 32'h3);
    check("c1_irqvec_16", 32'(Irq_Vec), 32'h1);
    step(1);
    check("c1_irqvec_17", 32'(Irq_Vec), 32'h3);
    check("c1_irq_17", 32'(IP_Interrupt), 32'h1);
    chk_rd("c0_cnt_17", 2, 32'd11);
    step(14);
    // W1C of bit1 lands on the same edge as ch1's second expiry
    wr(6, 32'h2, 4'hF);
    chk_rd("w1c_vs_exp", 6, 32'h3);
    chk_rd("c0_cnt_32", 2, 32'd26);
    chk_rd("c1_cnt_32", 5, 32'd4);
    wr(6, 32'h1, 4'hF);
    chk_rd("w1c_bit0", 6, 32'h2);

    // COUNT write is rejected
    wr(2, 32'h0000_1234, 4'hF);
    check("cntwr_wrack", 32'(wa), 32'h1);
    check("cntwr_err", 32'(we), 32'h1);
    chk_rd("cntwr_cnt", 2, 32'd24);

    // Non-one-hot read CE
    bus_if.Bus2IP_RdCE = 7'b1100000;
    #1;
    check("multi_rdack", 32'(bus_if.IP2Bus_RdAck), 32'h1);
    check("multi_err", 32'(bus_if.IP2Bus_Error), 32'h1);
    bus_if.Bus2IP_RdCE = '0;
    #1;

    // Byte enables on LOAD, CTRL readback masking
    wr(3, 32'h0, 4'hF);
    wr(4, 32'h1234_5678, 4'hF);
    wr(4, 32'hFFFF_FF05, 4'b0001);
    chk_rd("be_load", 4, 32'h1234_5605);
    chk_rd("be_cnt", 5, 32'h1234_5605);
    wr(3, 32'hFFFF_FFFF, 4'hF);
    chk_rd("ctrl_mask", 3, 32'h0000_0FF7);
    chk_rd("ctrl_no_cnt", 5, 32'h1234_5605);
    step(1);
    check("ie_irqvec", 32'(Irq_Vec), 32'h2);
    check("ie_irq", 32'(IP_Interrupt), 32'h1);

    // Asynchronous reset mid-count
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_irq", 32'(IP_Interrupt), 32'h0);
    check("arst_irqvec", 32'(Irq_Vec), 32'h0);
    for (int k = 0; k < 7; k++) begin
      rd(k, rd_d, rd_a, rd_e);
      check($sformatf("arst_reg%0d", k), rd_d, 32'h0);
    end
    step(2);
    rst_n = 1'b1;
    step(3);
    chk_rd("post_cnt0", 2, 32'h0);
    chk_rd("post_ctrl1", 3, 32'h0);
    check("post_irq", 32'(IP_Interrupt), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
